// File: rtl/mem_port_arbiter.sv
// Serialises the CPU fetch and data ports onto one single-port synchronous RAM.
// Counts the RAM read latency and registers the returned data for each port.
module mem_port_arbiter #(
  parameter int AW     = 32,
  parameter int DW     = 32,
  parameter int RD_LAT = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          inst_req,
  input  logic [AW-1:0] inst_addr,
  output logic [DW-1:0] inst_data,
  output logic          inst_ready,
  input  logic          mem_req,
  input  logic          mem_we,
  input  logic [AW-1:0] mem_addr,
  input  logic [DW-1:0] mem_data,
  output logic [DW-1:0] mem_data_in,
  output logic          MIO_ready,
  output logic          ram_en,
  output logic          ram_we,
  output logic [AW-3:0] ram_addr,
  output logic [DW-1:0] ram_wdata,
  input  logic [DW-1:0] ram_rdata
);

  // state | meaning
  // IDLE  | sample requests, grant one port and launch the RAM strobe
  // ACC   | ram_en high for this cycle; store finishes, load starts counting
  // WAIT  | count down the read latency
  // DONE  | result registered, done pulse high, no request sampled
  typedef enum logic [1:0] {IDLE, ACC, WAIT, DONE} state_t;

  state_t     state, state_nxt;
  logic       gnt_d;
  logic       last_d;
  logic       d_done;
  logic       i_done;
  logic [1:0] cnt;
  logic       grant_any;
  logic       grant_data;
  logic       unused_addr_bits;

  assign unused_addr_bits = ^{inst_addr[1:0], mem_addr[1:0]};

  // Starvation guard: after a data access, a pending fetch goes first.
  assign grant_any  = mem_req | inst_req;
  assign grant_data = mem_req & ~(last_d & inst_req);

  assign MIO_ready  = ~mem_req  | d_done;
  assign inst_ready = ~inst_req | i_done;

  // Loads always pass through WAIT so the capture lands RD_LAT edges after the RAM strobe.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (grant_any) state_nxt = ACC;
      ACC:     state_nxt = ram_we ? DONE : WAIT;
      WAIT:    if (cnt == 2'd0) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ram_en      <= 1'b0;
      ram_we      <= 1'b0;
      ram_addr    <= '0;
      ram_wdata   <= '0;
      gnt_d       <= 1'b0;
      last_d      <= 1'b0;
      cnt         <= 2'd0;
      d_done      <= 1'b0;
      i_done      <= 1'b0;
      inst_data   <= '0;
      mem_data_in <= '0;
    end else begin
      ram_en <= 1'b0;
      d_done <= 1'b0;
      i_done <= 1'b0;
      case (state)
        IDLE: begin
          if (grant_any) begin
            ram_en    <= 1'b1;
            gnt_d     <= grant_data;
            ram_addr  <= grant_data ? mem_addr[AW-1:2] : inst_addr[AW-1:2];
            ram_we    <= grant_data & mem_we;
            ram_wdata <= grant_data ? mem_data : '0;
          end
        end
        ACC: begin
          ram_we <= 1'b0;
          cnt    <= 2'(RD_LAT - 1);
        end
        WAIT: begin
          if (cnt != 2'd0) cnt <= cnt - 2'd1;
          else if (gnt_d) mem_data_in <= ram_rdata;
          else            inst_data   <= ram_rdata;
        end
        default: ;
      endcase
      if (state != DONE && state_nxt == DONE) begin
        d_done <= gnt_d;
        i_done <= ~gnt_d;
        last_d <= gnt_d;
      end
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: three instances with RD_LAT = 1, 2, 4,
// each with a small RAM model whose read data is a fixed function of the word address.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        inst_req    [3];
  logic [31:0] inst_addr   [3];
  logic [31:0] inst_data   [3];
  logic        inst_ready  [3];
  logic        mem_req     [3];
  logic        mem_we      [3];
  logic [31:0] mem_addr    [3];
  logic [31:0] mem_data    [3];
  logic [31:0] mem_data_in [3];
  logic        MIO_ready   [3];
  logic        ram_en      [3];
  logic        ram_we      [3];
  logic [29:0] ram_addr    [3];
  logic [31:0] ram_wdata   [3];
  logic [31:0] ram_rdata   [3];

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] ram_val(input logic [29:0] a);
    case (a)
      30'h1:   ram_val = 32'h5A5A5A5A;
      30'h2:   ram_val = 32'h2001000B;
      default: ram_val = 32'hC0000000 | {2'b00, a};
    endcase
  endfunction

  for (genvar g = 0; g < 3; g++) begin : gen_dut
    localparam int LAT = (g == 0) ? 1 : (g == 1) ? 2 : 4;
    logic [31:0] pipe [4];

    mem_port_arbiter #(.AW(32), .DW(32), .RD_LAT(LAT)) u_dut (
      .clk        (clk),
      .rst        (rst),
      .inst_req   (inst_req[g]),
      .inst_addr  (inst_addr[g]),
      .inst_data  (inst_data[g]),
      .inst_ready (inst_ready[g]),
      .mem_req    (mem_req[g]),
      .mem_we     (mem_we[g]),
      .mem_addr   (mem_addr[g]),
      .mem_data   (mem_data[g]),
      .mem_data_in(mem_data_in[g]),
      .MIO_ready  (MIO_ready[g]),
      .ram_en     (ram_en[g]),
      .ram_we     (ram_we[g]),
      .ram_addr   (ram_addr[g]),
      .ram_wdata  (ram_wdata[g]),
      .ram_rdata  (ram_rdata[g])
    );

    always @(posedge clk) begin
      if (ram_en[g] && !ram_we[g]) pipe[0] <= ram_val(ram_addr[g]);
      for (int k = 1; k < 4; k++) pipe[k] <= pipe[k-1];
    end
    assign ram_rdata[g] = pipe[LAT-1];
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #2;
    for (int g = 0; g < 3; g++) begin
      n_vec++; if (ram_en[g] !== 1'b0) begin n_bad++; $display("FAIL rst_ram_en[%0d]: got %b want 0", g, ram_en[g]); end
      n_vec++; if (ram_addr[g] !== 30'h0) begin n_bad++; $display("FAIL rst_ram_addr[%0d]: got %h want 0", g, ram_addr[g]); end
      n_vec++; if (inst_data[g] !== 32'h0) begin n_bad++; $display("FAIL rst_inst_data[%0d]: got %h want 0", g, inst_data[g]); end
      n_vec++; if (mem_data_in[g] !== 32'h0) begin n_bad++; $display("FAIL rst_mem_data_in[%0d]: got %h want 0", g, mem_data_in[g]); end
      n_vec++; if (MIO_ready[g] !== 1'b1) begin n_bad++; $display("FAIL rst_MIO_ready[%0d]: got %b want 1", g, MIO_ready[g]); end
      n_vec++; if (inst_ready[g] !== 1'b1) begin n_bad++; $display("FAIL rst_inst_ready[%0d]: got %b want 1", g, inst_ready[g]); end
    end
    tick();
    rst = 1'b1;
    tick();
  endtask

  task automatic test_load_lat1();
    mem_req[0] = 1'b1; mem_we[0] = 1'b0; mem_addr[0] = 32'h4;
    #1;
    n_vec++; if (MIO_ready[0] !== 1'b0) begin n_bad++; $display("FAIL load_ready_req: got %b want 0", MIO_ready[0]); end
    tick();
    n_vec++; if (ram_en[0] !== 1'b1) begin n_bad++; $display("FAIL load_ram_en: got %b want 1", ram_en[0]); end
    n_vec++; if (ram_addr[0] !== 30'h1) begin n_bad++; $display("FAIL load_ram_addr: got %h want 1", ram_addr[0]); end
    n_vec++; if (ram_we[0] !== 1'b0) begin n_bad++; $display("FAIL load_ram_we: got %b want 0", ram_we[0]); end
    n_vec++; if (MIO_ready[0] !== 1'b0) begin n_bad++; $display("FAIL load_ready_e0: got %b want 0", MIO_ready[0]); end
    tick();
    n_vec++; if (ram_en[0] !== 1'b0) begin n_bad++; $display("FAIL load_ram_en_e1: got %b want 0", ram_en[0]); end
    n_vec++; if (MIO_ready[0] !== 1'b0) begin n_bad++; $display("FAIL load_ready_e1: got %b want 0", MIO_ready[0]); end
    tick();
    n_vec++; if (MIO_ready[0] !== 1'b1) begin n_bad++; $display("FAIL load_ready_e2: got %b want 1", MIO_ready[0]); end
    n_vec++; if (mem_data_in[0] !== 32'h5A5A5A5A) begin n_bad++; $display("FAIL load_data: got %h want 5a5a5a5a", mem_data_in[0]); end
    mem_req[0] = 1'b0;
    tick();
    n_vec++; if (ram_en[0] !== 1'b0) begin n_bad++; $display("FAIL load_no_regrant: got %b want 0", ram_en[0]); end
    n_vec++; if (mem_data_in[0] !== 32'h5A5A5A5A) begin n_bad++; $display("FAIL load_data_hold: got %h want 5a5a5a5a", mem_data_in[0]); end
  endtask

  task automatic test_store();
    mem_req[0] = 1'b1; mem_we[0] = 1'b1; mem_addr[0] = 32'hFFFFFFFC; mem_data[0] = 32'h2;
    #1;
    n_vec++; if (MIO_ready[0] !== 1'b0) begin n_bad++; $display("FAIL st_ready_req: got %b want 0", MIO_ready[0]); end
    tick();
    n_vec++; if (ram_en[0] !== 1'b1) begin n_bad++; $display("FAIL st_ram_en: got %b want 1", ram_en[0]); end
    n_vec++; if (ram_we[0] !== 1'b1) begin n_bad++; $display("FAIL st_ram_we: got %b want 1", ram_we[0]); end
    n_vec++; if (ram_wdata[0] !== 32'h2) begin n_bad++; $display("FAIL st_ram_wdata: got %h want 2", ram_wdata[0]); end
    n_vec++; if (ram_addr[0] !== 30'h3FFFFFFF) begin n_bad++; $display("FAIL st_ram_addr: got %h want 3fffffff", ram_addr[0]); end
    tick();
    n_vec++; if (ram_en[0] !== 1'b0) begin n_bad++; $display("FAIL st_ram_en_e1: got %b want 0", ram_en[0]); end
    n_vec++; if (MIO_ready[0] !== 1'b1) begin n_bad++; $display("FAIL st_ready_e1: got %b want 1", MIO_ready[0]); end
    n_vec++; if (mem_data_in[0] !== 32'h5A5A5A5A) begin n_bad++; $display("FAIL st_data_kept: got %h want 5a5a5a5a", mem_data_in[0]); end
    mem_req[0] = 1'b0; mem_we[0] = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid_load();
    mem_req[1] = 1'b1; mem_we[1] = 1'b0; mem_addr[1] = 32'h4;
    tick();
    n_vec++; if (ram_addr[1] !== 30'h1) begin n_bad++; $display("FAIL l2_ram_addr: got %h want 1", ram_addr[1]); end
    tick();
    tick();
    n_vec++; if (mem_data_in[1] !== 32'h0) begin n_bad++; $display("FAIL l2_early: got %h want 0", mem_data_in[1]); end
    n_vec++; if (MIO_ready[1] !== 1'b0) begin n_bad++; $display("FAIL l2_ready_e2: got %b want 0", MIO_ready[1]); end
    tick();
    n_vec++; if (mem_data_in[1] !== 32'h5A5A5A5A) begin n_bad++; $display("FAIL l2_data: got %h want 5a5a5a5a", mem_data_in[1]); end
    n_vec++; if (MIO_ready[1] !== 1'b1) begin n_bad++; $display("FAIL l2_ready_e3: got %b want 1", MIO_ready[1]); end
    mem_req[1] = 1'b0;
    tick();
    tick();
    mem_req[1] = 1'b1; mem_addr[1] = 32'h10;
    tick();
    n_vec++; if (ram_en[1] !== 1'b1) begin n_bad++; $display("FAIL mid_ram_en_e0: got %b want 1", ram_en[1]); end
    tick();
    rst = 1'b0;
    #1;
    n_vec++; if (ram_en[1] !== 1'b0) begin n_bad++; $display("FAIL mid_ram_en: got %b want 0", ram_en[1]); end
    n_vec++; if (mem_data_in[1] !== 32'h0) begin n_bad++; $display("FAIL mid_data: got %h want 0", mem_data_in[1]); end
    n_vec++; if (mem_data_in[0] !== 32'h0) begin n_bad++; $display("FAIL mid_data_other: got %h want 0", mem_data_in[0]); end
    n_vec++; if (MIO_ready[1] !== 1'b0) begin n_bad++; $display("FAIL mid_ready_held: got %b want 0", MIO_ready[1]); end
    mem_req[1] = 1'b0;
    #1;
    n_vec++; if (MIO_ready[1] !== 1'b1) begin n_bad++; $display("FAIL mid_ready_idle: got %b want 1", MIO_ready[1]); end
    tick();
    rst = 1'b1;
    inst_req[1] = 1'b1; inst_addr[1] = 32'h4;
    tick();
    n_vec++; if (ram_en[1] !== 1'b1) begin n_bad++; $display("FAIL post_rst_en: got %b want 1", ram_en[1]); end
    n_vec++; if (ram_addr[1] !== 30'h1) begin n_bad++; $display("FAIL post_rst_addr: got %h want 1", ram_addr[1]); end
    n_vec++; if (ram_we[1] !== 1'b0) begin n_bad++; $display("FAIL post_rst_we: got %b want 0", ram_we[1]); end
    tick();
    tick();
    tick();
    n_vec++; if (inst_data[1] !== 32'h5A5A5A5A) begin n_bad++; $display("FAIL post_rst_idata: got %h want 5a5a5a5a", inst_data[1]); end
    n_vec++; if (inst_ready[1] !== 1'b1) begin n_bad++; $display("FAIL post_rst_iready: got %b want 1", inst_ready[1]); end
    inst_req[1] = 1'b0;
    tick();
  endtask

  task automatic test_contention();
    logic [29:0] exp_addr [4] = '{30'h4, 30'h2, 30'h4, 30'h2};
    int          exp_edge [4] = '{1, 5, 9, 13};
    logic [29:0] g_addr [4];
    int          g_edge [4];
    int          n_g = 0;
    int          n_we = 0;
    int          cap_at = 0;
    mem_req[0] = 1'b1; mem_we[0] = 1'b0; mem_addr[0] = 32'h10;
    inst_req[0] = 1'b1; inst_addr[0] = 32'h8;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (ram_en[0] === 1'b1) begin
        if (n_g < 4) begin g_addr[n_g] = ram_addr[0]; g_edge[n_g] = i; end
        if (ram_we[0] !== 1'b0) n_we++;
        n_g++;
      end
      if (cap_at == 0 && inst_data[0] === 32'h2001000B) cap_at = i;
    end
    mem_req[0] = 1'b0; inst_req[0] = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    n_vec++; if (n_g < 4) begin n_bad++; $display("FAIL cont_grants: got %0d want >=4", n_g); end
    for (int k = 0; k < 4; k++) begin
      if (k < n_g) begin
        n_vec++; if (g_addr[k] !== exp_addr[k]) begin n_bad++; $display("FAIL cont_order[%0d]: got %h want %h", k, g_addr[k], exp_addr[k]); end
        n_vec++; if (g_edge[k] != exp_edge[k]) begin n_bad++; $display("FAIL cont_edge[%0d]: got %0d want %0d", k, g_edge[k], exp_edge[k]); end
      end
    end
    n_vec++; if (n_we != 0) begin n_bad++; $display("FAIL cont_we: got %0d writes want 0", n_we); end
    n_vec++; if (cap_at != 7) begin n_bad++; $display("FAIL cont_icap_edge: got %0d want 7", cap_at); end
    n_vec++; if (inst_data[0] !== 32'h2001000B) begin n_bad++; $display("FAIL cont_idata: got %h want 2001000b", inst_data[0]); end
    n_vec++; if (mem_data_in[0] !== 32'hC0000004) begin n_bad++; $display("FAIL cont_ddata: got %h want c0000004", mem_data_in[0]); end
  endtask

  task automatic test_fetch_lat4();
    inst_req[2] = 1'b1; inst_addr[2] = 32'hC;
    #1;
    n_vec++; if (inst_ready[2] !== 1'b0) begin n_bad++; $display("FAIL f4_ready_req: got %b want 0", inst_ready[2]); end
    for (int k = 0; k < 5; k++) begin
      tick();
      n_vec++; if (inst_ready[2] !== 1'b0) begin n_bad++; $display("FAIL f4_ready_e%0d: got %b want 0", k, inst_ready[2]); end
      if (k == 0) begin
        n_vec++; if (ram_en[2] !== 1'b1) begin n_bad++; $display("FAIL f4_ram_en: got %b want 1", ram_en[2]); end
        n_vec++; if (ram_addr[2] !== 30'h3) begin n_bad++; $display("FAIL f4_ram_addr: got %h want 3", ram_addr[2]); end
      end
      if (k == 4) begin
        n_vec++; if (inst_data[2] !== 32'h0) begin n_bad++; $display("FAIL f4_early: got %h want 0", inst_data[2]); end
      end
    end
    tick();
    n_vec++; if (inst_ready[2] !== 1'b1) begin n_bad++; $display("FAIL f4_done: got %b want 1", inst_ready[2]); end
    n_vec++; if (inst_data[2] !== 32'hC0000003) begin n_bad++; $display("FAIL f4_data: got %h want c0000003", inst_data[2]); end
    inst_req[2] = 1'b0;
    tick();
    n_vec++; if (inst_ready[2] !== 1'b1) begin n_bad++; $display("FAIL f4_idle_ready: got %b want 1", inst_ready[2]); end
  endtask

  task automatic test_back_to_back();
    int n_en = 0;
    int e1 = 0;
    int e2 = 0;
    int rdy_at = 0;
    mem_req[0] = 1'b1; mem_we[0] = 1'b1; mem_addr[0] = 32'h20; mem_data[0] = 32'h77;
    for (int i = 1; i <= 12; i++) begin
      tick();
      if (ram_en[0] === 1'b1) begin
        n_en++;
        if (n_en == 1) e1 = i;
        else if (n_en == 2) e2 = i;
      end
      if (rdy_at == 0 && MIO_ready[0] === 1'b1) rdy_at = i;
      if (rdy_at != 0 && i == rdy_at + 2) mem_req[0] = 1'b0;
    end
    mem_req[0] = 1'b0; mem_we[0] = 1'b0;
    n_vec++; if (rdy_at != 2) begin n_bad++; $display("FAIL b2b_ready_at: got %0d want 2", rdy_at); end
    n_vec++; if (n_en != 2) begin n_bad++; $display("FAIL b2b_accesses: got %0d want 2", n_en); end
    n_vec++; if (e1 != 1) begin n_bad++; $display("FAIL b2b_first: got %0d want 1", e1); end
    n_vec++; if (e2 != 4) begin n_bad++; $display("FAIL b2b_second: got %0d want 4", e2); end
    n_vec++; if (mem_data_in[0] !== 32'hC0000004) begin n_bad++; $display("FAIL b2b_data_kept: got %h want c0000004", mem_data_in[0]); end
  endtask

  initial begin
    rst = 1'b0;
    for (int g = 0; g < 3; g++) begin
      inst_req[g] = 1'b0; inst_addr[g] = '0;
      mem_req[g] = 1'b0; mem_we[g] = 1'b0; mem_addr[g] = '0; mem_data[g] = '0;
    end
    test_reset();
    test_load_lat1();
    test_store();
    test_reset_mid_load();
    test_contention();
    test_fetch_lat4();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
